// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry and the receiver state encoding.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_os_sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input, reset to a chosen level.
module sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampling 8N1 UART receiver: start-bit qualification, mid-bit sampling,
// valid/ready byte output with frame and overrun error pulses.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int unsigned OS_W = $clog2(OVERSAMPLE);
    localparam int unsigned BC_W = $clog2(DATA_BITS + 1);

    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    rx_state_t            r_state;
    logic [OS_W-1:0]      r_os_cnt;
    logic [BC_W-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_overrun_err;

    logic w_rx_s;
    logic w_stop_tick;
    logic w_done;
    logic w_bad;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx_in),
        .o_q   (w_rx_s)
    );

    // Mid-stop-bit tick: the frame is judged here and the FSM returns to IDLE.
    assign w_stop_tick = baud_tick && (r_state == RX_STOP) && (r_os_cnt == OS_LAST);
    assign w_done      = w_stop_tick && w_rx_s;
    assign w_bad       = w_stop_tick && !w_rx_s;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= RX_IDLE;
            r_os_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
        end else if (baud_tick) begin
            case (r_state)
                RX_IDLE: begin
                    if (!w_rx_s) begin
                        r_state  <= RX_START;
                        r_os_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (r_os_cnt == OS_MID) begin
                        if (w_rx_s) begin
                            r_state <= RX_IDLE;
                        end else begin
                            r_state   <= RX_DATA;
                            r_os_cnt  <= '0;
                            r_bit_cnt <= '0;
                        end
                    end else begin
                        r_os_cnt <= r_os_cnt + OS_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_os_cnt == OS_LAST) begin
                        r_shreg   <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
                        r_os_cnt  <= '0;
                        r_bit_cnt <= r_bit_cnt + BC_W'(1);
                        if (r_bit_cnt == BC_LAST) begin
                            r_state <= RX_STOP;
                        end
                    end else begin
                        r_os_cnt <= r_os_cnt + OS_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_os_cnt == OS_LAST) begin
                        r_state  <= RX_IDLE;
                        r_os_cnt <= '0;
                    end else begin
                        r_os_cnt <= r_os_cnt + OS_W'(1);
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    // Holding register: a completing byte may replace one being accepted in the same clk.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_frame_err   <= w_bad;
            r_overrun_err <= w_done && r_rx_valid && !rx_ready;
            if (w_done && (!r_rx_valid || rx_ready)) begin
                r_rx_data  <= r_shreg;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;
    assign busy        = (r_state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: 8N1 frames at 16x oversampling, baud_tick every 4 clks.
module tb_uart_rx_os;

    localparam int BIT_CLKS = 64;
    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       baud_tick;
    logic       rx_in;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int vec = 0;
    int err = 0;
    int cyc = 0;

    // Monitor state (written only by the negedge monitor)
    logic [7:0] got_q[$];
    int   fe_cnt    = 0;
    int   ov_cnt    = 0;
    int   vhigh_cnt = 0;
    int   busy_cnt  = 0;
    int   rise_cyc  = 0;
    logic prev_valid = 1'b0;

    uart_rx_os dut (
        .clk         (clk),
        .reset       (reset),
        .baud_tick   (baud_tick),
        .rx_in       (rx_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            baud_tick = (cyc % TICK_DIV == 0);
        end
    end

    always @(negedge clk) begin
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (overrun_err) ov_cnt = ov_cnt + 1;
        if (rx_valid) vhigh_cnt = vhigh_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_valid;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line-level reference: start 0, data LSB first, then the given stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_in = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            step(BIT_CLKS);
        end
        rx_in = stop;
        step(BIT_CLKS);
        rx_in = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_in = 1'b1; rx_ready = 1'b0;
        step(3);
        vec++; if (rx_valid !== 1'b0) begin err++; $display("FAIL reset_valid: got %b, expected 0", rx_valid); end
        vec++; if (rx_data !== 8'h00) begin err++; $display("FAIL reset_data: got %h, expected 00", rx_data); end
        vec++; if (frame_err !== 1'b0) begin err++; $display("FAIL reset_ferr: got %b, expected 0", frame_err); end
        vec++; if (overrun_err !== 1'b0) begin err++; $display("FAIL reset_ovr: got %b, expected 0", overrun_err); end
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        reset = 1'b1;
        step(4);
    endtask

    task automatic test_basic();
        int g0, f0, o0, v0, c0, lat;
        g0 = got_q.size(); f0 = fe_cnt; o0 = ov_cnt; v0 = vhigh_cnt;
        rx_ready = 1'b1;
        c0 = cyc;
        send_frame(8'hA5, 1'b1);
        step(32);
        lat = rise_cyc - c0;
        vec++; if (got_q.size() - g0 != 1) begin err++; $display("FAIL basic_count: got %0d bytes, expected 1", got_q.size() - g0); end
        vec++; if (got_q.size() > g0 && got_q[g0] !== 8'hA5) begin err++; $display("FAIL basic_data: got %h, expected a5", got_q[g0]); end
        vec++; if (vhigh_cnt - v0 != 1) begin err++; $display("FAIL basic_valid_len: got %0d clks, expected 1", vhigh_cnt - v0); end
        vec++; if (fe_cnt != f0 || ov_cnt != o0) begin err++; $display("FAIL basic_errs: got fe=%0d ov=%0d, expected 0 0", fe_cnt - f0, ov_cnt - o0); end
        vec++; if (lat < 611 || lat > 614) begin err++; $display("FAIL basic_latency: got %0d clks, expected 611..614", lat); end
    endtask

    task automatic test_glitch();
        int g0, f0, v0, b0;
        g0 = got_q.size(); f0 = fe_cnt; v0 = vhigh_cnt; b0 = busy_cnt;
        rx_in = 1'b0;
        step(4 * TICK_DIV);
        rx_in = 1'b1;
        step(BIT_CLKS);
        vec++; if (busy_cnt == b0) begin err++; $display("FAIL glitch_busy_seen: got 0 busy clks, expected >0"); end
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL glitch_busy_drop: got %b, expected 0", busy); end
        vec++; if (vhigh_cnt != v0 || got_q.size() != g0) begin err++; $display("FAIL glitch_valid: got %0d valid clks, expected 0", vhigh_cnt - v0); end
        vec++; if (fe_cnt != f0) begin err++; $display("FAIL glitch_ferr: got %0d pulses, expected 0", fe_cnt - f0); end
    endtask

    task automatic test_frame_err();
        int g0, f0, o0, v0;
        g0 = got_q.size(); f0 = fe_cnt; o0 = ov_cnt; v0 = vhigh_cnt;
        rx_ready = 1'b1;
        send_frame(8'h3C, 1'b0);
        step(2 * BIT_CLKS);
        vec++; if (fe_cnt - f0 != 1) begin err++; $display("FAIL ferr_pulse: got %0d pulses, expected 1", fe_cnt - f0); end
        vec++; if (vhigh_cnt != v0) begin err++; $display("FAIL ferr_valid: got %0d valid clks, expected 0", vhigh_cnt - v0); end
        vec++; if (ov_cnt != o0) begin err++; $display("FAIL ferr_ovr: got %0d pulses, expected 0", ov_cnt - o0); end
        send_frame(8'h55, 1'b1);
        step(32);
        vec++; if (got_q.size() - g0 != 1) begin err++; $display("FAIL ferr_next_count: got %0d bytes, expected 1", got_q.size() - g0); end
        vec++; if (got_q.size() > g0 && got_q[g0] !== 8'h55) begin err++; $display("FAIL ferr_next_data: got %h, expected 55", got_q[g0]); end
        vec++; if (fe_cnt - f0 != 1) begin err++; $display("FAIL ferr_next_clean: got %0d pulses, expected 1", fe_cnt - f0); end
    endtask

    task automatic test_overrun();
        int g0, f0, o0;
        g0 = got_q.size(); f0 = fe_cnt; o0 = ov_cnt;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        step(BIT_CLKS);
        send_frame(8'h22, 1'b1);
        step(BIT_CLKS);
        vec++; if (rx_valid !== 1'b1) begin err++; $display("FAIL ovr_valid: got %b, expected 1", rx_valid); end
        vec++; if (rx_data !== 8'h11) begin err++; $display("FAIL ovr_data: got %h, expected 11", rx_data); end
        vec++; if (ov_cnt - o0 != 1) begin err++; $display("FAIL ovr_pulse: got %0d pulses, expected 1", ov_cnt - o0); end
        vec++; if (fe_cnt != f0) begin err++; $display("FAIL ovr_ferr: got %0d pulses, expected 0", fe_cnt - f0); end
        rx_ready = 1'b1;
        step(1);
        vec++; if (rx_valid !== 1'b0) begin err++; $display("FAIL ovr_accept: got valid %b, expected 0", rx_valid); end
        vec++; if (rx_data !== 8'h11) begin err++; $display("FAIL ovr_hold: got %h, expected 11", rx_data); end
        vec++; if (got_q.size() - g0 != 1 || (got_q.size() > g0 && got_q[g0] !== 8'h11)) begin err++; $display("FAIL ovr_taken: got %0d bytes, expected one byte 11", got_q.size() - g0); end
    endtask

    task automatic test_back_to_back();
        int g0, f0, o0, c1, lat, target;
        logic [7:0] exp_b[3];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h81;
        g0 = got_q.size(); f0 = fe_cnt; o0 = ov_cnt;
        rx_ready = 1'b1;
        c1 = cyc;
        fork
            begin
                for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
            end
            begin
                // Hold the second byte, then accept it in the clk the third byte completes.
                for (int k = 0; k < 800 && got_q.size() == g0; k++) step(1);
                vec++; if (got_q.size() == g0) begin err++; $display("FAIL b2b_first_timeout: got no byte, expected 00"); end
                lat = (got_q.size() == g0) ? 612 : rise_cyc - c1;
                rx_ready = 1'b0;
                target = c1 + 2 * 10 * BIT_CLKS + lat - 1;
                while (cyc < target) step(1);
                rx_ready = 1'b1;
                step(1);
                vec++; if (rx_valid !== 1'b1 || rx_data !== 8'h81) begin err++; $display("FAIL b2b_same_clk: got valid=%b data=%h, expected 1 81", rx_valid, rx_data); end
                step(1);
                vec++; if (rx_valid !== 1'b0) begin err++; $display("FAIL b2b_drain: got valid %b, expected 0", rx_valid); end
            end
        join
        step(32);
        vec++; if (got_q.size() - g0 != 3) begin err++; $display("FAIL b2b_count: got %0d bytes, expected 3", got_q.size() - g0); end
        for (int i = 0; i < 3; i++) begin
            vec++; if (got_q.size() <= g0 + i || got_q[g0 + i] !== exp_b[i]) begin err++; $display("FAIL b2b_byte%0d: got %h, expected %h", i, (got_q.size() > g0 + i) ? got_q[g0 + i] : 8'hxx, exp_b[i]); end
        end
        vec++; if (ov_cnt != o0 || fe_cnt != f0) begin err++; $display("FAIL b2b_errs: got ov=%0d fe=%0d, expected 0 0", ov_cnt - o0, fe_cnt - f0); end
    endtask

    task automatic test_reset_mid();
        int g0, f0, o0;
        logic [7:0] b;
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1);
        step(32);
        vec++; if (rx_valid !== 1'b1) begin err++; $display("FAIL rstmid_pre_valid: got %b, expected 1", rx_valid); end
        b = 8'h7E;
        rx_in = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rx_in = b[i];
            step(BIT_CLKS);
        end
        rx_in = b[3];
        step(BIT_CLKS / 2);
        vec++; if (busy !== 1'b1) begin err++; $display("FAIL rstmid_busy_pre: got %b, expected 1", busy); end
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        vec++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin err++; $display("FAIL rstmid_out: got valid=%b data=%h, expected 0 00", rx_valid, rx_data); end
        vec++; if (busy !== 1'b0 || frame_err !== 1'b0 || overrun_err !== 1'b0) begin err++; $display("FAIL rstmid_flags: got busy=%b fe=%b ov=%b, expected 0 0 0", busy, frame_err, overrun_err); end
        rx_in = 1'b1;
        step(2 * BIT_CLKS);
        g0 = got_q.size(); f0 = fe_cnt; o0 = ov_cnt;
        rx_ready = 1'b1;
        send_frame(8'h7E, 1'b1);
        step(32);
        vec++; if (got_q.size() - g0 != 1 || (got_q.size() > g0 && got_q[g0] !== 8'h7E)) begin err++; $display("FAIL rstmid_next: got %0d bytes, expected one byte 7e", got_q.size() - g0); end
        vec++; if (fe_cnt != f0 || ov_cnt != o0) begin err++; $display("FAIL rstmid_errs: got fe=%0d ov=%0d, expected 0 0", fe_cnt - f0, ov_cnt - o0); end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int g0, f0, exp_fe;
        logic [7:0] b;
        logic st;
        g0 = got_q.size(); f0 = fe_cnt; exp_fe = 0;
        rx_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 3) != 0);
            send_frame(b, st);
            if (st) exp_q.push_back(b);
            else exp_fe++;
            step(BIT_CLKS * int'($urandom_range(2, 3)));
        end
        step(32);
        vec++; if (got_q.size() - g0 != exp_q.size()) begin err++; $display("FAIL rand_count: got %0d bytes, expected %0d", got_q.size() - g0, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vec++; if (got_q.size() <= g0 + i || got_q[g0 + i] !== exp_q[i]) begin err++; $display("FAIL rand_byte%0d: got %h, expected %h", i, (got_q.size() > g0 + i) ? got_q[g0 + i] : 8'hxx, exp_q[i]); end
        end
        vec++; if (fe_cnt - f0 != exp_fe) begin err++; $display("FAIL rand_ferr: got %0d pulses, expected %0d", fe_cnt - f0, exp_fe); end
    endtask

    initial begin
        reset = 1'b0;
        rx_in = 1'b1;
        rx_ready = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
